muldiv_hilo_ctrl: RTL and testbench
===================================

Name: muldiv_hilo_ctrl

Overview:
- Iterative multiply/divide sequencer that owns the HI/LO register pair for the EX stage.
- Accepts mult/multu/div/divu from decode, runs a 32-iteration shift-add or restoring-divide datapath, and writes HI/LO on completion.
- Services mthi/mtlo writes directly.
- Drives a stall to the pipeline whenever an instruction touches HI/LO or starts a new operation while the unit is busy.

Parameters:
- ITER, 32, iteration count for multiply/divide; fixed at 32 for the 32-bit datapath. Sizes the iteration counter.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous reset, active-high
- md_start  in  1  mult/div issue strobe from decode, qualified valid
- md_op  in  2  00 mult, 01 multu, 10 div, 11 divu
- src_a  in  32  rs operand (multiplicand / dividend)
- src_b  in  32  rt operand (multiplier / divisor)
- mthi  in  1  write wdata to HI
- mtlo  in  1  write wdata to LO
- wdata  in  32  mthi/mtlo data
- rd_hi  in  1  mfhi in EX needs HI
- rd_lo  in  1  mflo in EX needs LO
- hi  out  32  HI register
- lo  out  32  LO register
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse, HI/LO just updated by a mul/div
- stall  out  1  freeze PC/IF/ID, bubble EX

Behaviour:
- Reset (rst=1 at an edge): state IDLE; hi=0, lo=0, busy=0, done=0; counter, partial-product and remainder registers cleared.
- Reset mid-operation: aborts immediately; HI/LO go to 0, and no done pulse is generated.
- FSM states:
  - IDLE: waiting for work.
  - MUL: shift-add multiply loop.
  - DIV: restoring-divide loop.
- IDLE with md_start=1 at edge E0:
  - Latch |src_a|, |src_b| for signed ops, raw values for unsigned ops.
  - Latch result signs: product sign = a31^b31; quotient sign = a31^b31; remainder sign = a31.
  - Counter=0; go to MUL or DIV; busy=1 from the cycle after E0.
- MUL: one shift-add per edge, counter increments. At the edge where counter==ITER-1 (E32):
  - Write {hi,lo} = 64-bit product, two's-complement negated if the sign flag is set (signed only).
  - Return to IDLE; busy=0 and done=1 during the cycle after E32.
- DIV: one restoring step per edge, same 32-edge timing.
  - At E32: lo = quotient, hi = remainder, each sign-corrected for div.
- Divide by zero (src_b==0 with div/divu): no iteration.
  - At E1: hi=src_a, lo=32'hFFFFFFFF, done=1 in the following cycle, busy high for exactly one cycle.
- Signed overflow case div 0x80000000 / -1: lo=0x80000000, hi=0 (natural result of magnitude arithmetic).
- done: registered, high for exactly one cycle; deasserted at every other time.
- stall = busy & (md_start | rd_hi | rd_lo | mthi | mtlo). Purely combinational from busy and the inputs.
  - The requester holds its request until stall drops.
  - md_start while busy is ignored; the pipeline re-presents it.
- mthi/mtlo with busy=0: hi/lo := wdata at the edge.
  - Both asserted together: both written.
  - Simultaneous with md_start while idle: md_start wins, mthi/mtlo dropped (decode never issues both).
- rd_hi/rd_lo with busy=0: no stall; hi/lo outputs are read directly. Writes appear the cycle after the edge, with no bypass.
- HI/LO hold their values in every cycle not listed above.

Optional Feature:
- FAST_MUL_EN
- Defined:
  - mult/multu compute the 64-bit product combinationally (signed/unsigned multiply operator).
  - HI/LO are written at E1; busy is high one cycle; done follows the E1 edge.
  - Divide remains iterative.
- Undefined:
  - Multiply uses the 32-iteration MUL state; no hardware multiplier is inferred.

Test Plan:
- mult, src_a=-3 (FFFFFFFD), src_b=5 -> hi=FFFFFFFF, lo=FFFFFFF1. busy high 32 cycles; done pulses in cycle 33 after issue (cycle 2 with FAST_MUL_EN).
- multu, 0xFFFFFFFF × 0xFFFFFFFF -> hi=FFFFFFFE, lo=00000001.
- div, 7 / -2 -> lo=FFFFFFFD, hi=00000001. divu, 0xFFFFFFFF / 0x10 -> lo=0FFFFFFF, hi=0000000F.
- div, 0x1234 / 0 -> hi=00001234, lo=FFFFFFFF. busy exactly 1 cycle, done at cycle 2.
- Start mult, then hold rd_lo=1 and later md_start=1 during the run -> stall=1 every busy cycle, stall=0 in the done cycle. Second start is ignored while busy and accepted once idle.
- mthi 0xA5A5A5A5 while idle -> hi=A5A5A5A5 next cycle, no stall. rst at cycle 10 of a div -> busy=0, hi=lo=0, no done pulse.

Source files
------------

// File: rtl/muldiv_hilo_ctrl.sv
// muldiv_hilo_ctrl: iterative multiply/divide sequencer owning the HI/LO pair.
// Runs a 32-step shift-add multiply or restoring divide on operand magnitudes,
// applies sign correction at the end, and services mthi/mtlo while idle.
// Optional build macro FAST_MUL_EN: single-cycle multiply via the '*' operator;
// divide stays iterative. Without it, no hardware multiplier is inferred.
module muldiv_hilo_ctrl #(
    parameter int unsigned ITER = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        md_start,
    input  logic [1:0]  md_op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        mthi,
    input  logic        mtlo,
    input  logic [31:0] wdata,
    input  logic        rd_hi,
    input  logic        rd_lo,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done,
    output logic        stall
);

    localparam int unsigned DW    = 32;
    localparam int unsigned CNT_W = (ITER > 1) ? $clog2(ITER) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2
    } state_t;

    state_t             r_state;
    logic [DW-1:0]      r_hi;
    logic [DW-1:0]      r_lo;
    logic [DW-1:0]      r_m;
    logic [2*DW-1:0]    r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_busy;
    logic               r_done;
    logic               r_neg_qp;
    logic               r_neg_r;
    logic               r_dz;

    logic               w_signed;
    logic               w_is_div;
    logic               w_last;
    logic [DW-1:0]      w_abs_a;
    logic [DW-1:0]      w_abs_b;
    logic [DW:0]        w_trial;
    logic [DW:0]        w_diff;
    logic [2*DW-1:0]    w_div_next;
    logic [DW-1:0]      w_quot;
    logic [DW-1:0]      w_rem;
`ifdef FAST_MUL_EN
    logic [2*DW-1:0]    w_ext_a;
    logic [2*DW-1:0]    w_ext_b;
    logic [2*DW-1:0]    w_fast;
`else
    logic [DW:0]        w_add;
    logic [2*DW-1:0]    w_mul_next;
    logic [2*DW-1:0]    w_prod;
`endif

    // Operand decode, magnitudes and one datapath step for each algorithm
    always_comb begin
        w_signed = ~md_op[0];
        w_is_div = md_op[1];
        w_last   = (r_cnt == CNT_W'(ITER - 1));
        w_abs_a  = (w_signed & src_a[DW-1]) ? (~src_a + DW'(1)) : src_a;
        w_abs_b  = (w_signed & src_b[DW-1]) ? (~src_b + DW'(1)) : src_b;

        // Restoring divide: shift {rem,quot} left, keep the subtraction if it did not borrow
        w_trial  = r_acc[2*DW-1:DW-1];
        w_diff   = w_trial - {1'b0, r_m};
        if (w_diff[DW]) begin
            w_div_next = {w_trial[DW-1:0], r_acc[DW-2:0], 1'b0};
        end else begin
            w_div_next = {w_diff[DW-1:0], r_acc[DW-2:0], 1'b1};
        end
        w_quot = r_neg_qp ? (~w_div_next[DW-1:0] + DW'(1)) : w_div_next[DW-1:0];
        w_rem  = r_neg_r ? (~w_div_next[2*DW-1:DW] + DW'(1)) : w_div_next[2*DW-1:DW];

`ifdef FAST_MUL_EN
        w_ext_a = w_signed ? {{DW{src_a[DW-1]}}, src_a} : {{DW{1'b0}}, src_a};
        w_ext_b = w_signed ? {{DW{src_b[DW-1]}}, src_b} : {{DW{1'b0}}, src_b};
        w_fast  = w_ext_a * w_ext_b;
`else
        // Shift-add multiply: add multiplicand to the upper half when the multiplier LSB is set
        w_add      = {1'b0, r_acc[2*DW-1:DW]} + (r_acc[0] ? {1'b0, r_m} : {(DW+1){1'b0}});
        w_mul_next = {w_add, r_acc[DW-1:1]};
        w_prod     = r_neg_qp ? (~w_mul_next + (2*DW)'(1)) : w_mul_next;
`endif
    end

    // Sequencer FSM, HI/LO ownership and registered status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_hi     <= '0;
            r_lo     <= '0;
            r_m      <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_neg_qp <= 1'b0;
            r_neg_r  <= 1'b0;
            r_dz     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (md_start) begin
                        r_busy   <= 1'b1;
                        r_cnt    <= '0;
                        r_neg_qp <= w_signed & (src_a[DW-1] ^ src_b[DW-1]);
                        r_neg_r  <= w_signed & src_a[DW-1];
                        if (w_is_div) begin
                            r_state <= S_DIV;
                            r_m     <= w_abs_b;
                            r_dz    <= (src_b == '0);
                            // Divide by zero keeps the raw dividend so HI returns src_a unchanged
                            r_acc   <= (src_b == '0) ? {{DW{1'b0}}, src_a} : {{DW{1'b0}}, w_abs_a};
                        end else begin
                            r_state <= S_MUL;
                            r_dz    <= 1'b0;
                            r_m     <= w_abs_a;
`ifdef FAST_MUL_EN
                            r_acc   <= w_fast;
`else
                            r_acc   <= {{DW{1'b0}}, w_abs_b};
`endif
                        end
                    end else begin
                        if (mthi) begin
                            r_hi <= wdata;
                        end
                        if (mtlo) begin
                            r_lo <= wdata;
                        end
                    end
                end
                S_MUL: begin
`ifdef FAST_MUL_EN
                    r_hi    <= r_acc[2*DW-1:DW];
                    r_lo    <= r_acc[DW-1:0];
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
`else
                    r_acc <= w_mul_next;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_hi    <= w_prod[2*DW-1:DW];
                        r_lo    <= w_prod[DW-1:0];
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
`endif
                end
                S_DIV: begin
                    if (r_dz) begin
                        r_hi    <= r_acc[DW-1:0];
                        r_lo    <= '1;
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_acc <= w_div_next;
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (w_last) begin
                            r_hi    <= w_rem;
                            r_lo    <= w_quot;
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign hi    = r_hi;
    assign lo    = r_lo;
    assign busy  = r_busy;
    assign done  = r_done;
    // Freeze the front of the pipeline for any HI/LO access or new issue while busy
    assign stall = r_busy & (md_start | rd_hi | rd_lo | mthi | mtlo);

endmodule

// File: tb/tb_muldiv_hilo_ctrl.sv
// Self-checking bench for muldiv_hilo_ctrl: directed vector table, random ops
// against an arithmetic reference model, and hand-written stall/mthi/reset sequences.
module tb_muldiv_hilo_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        md_start;
    logic [1:0]  md_op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        mthi;
    logic        mtlo;
    logic [31:0] wdata;
    logic        rd_hi;
    logic        rd_lo;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        stall;

    int n_checks = 0;
    int n_errors = 0;

    muldiv_hilo_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .md_start (md_start),
        .md_op    (md_op),
        .src_a    (src_a),
        .src_b    (src_b),
        .mthi     (mthi),
        .mtlo     (mtlo),
        .wdata    (wdata),
        .rd_hi    (rd_hi),
        .rd_lo    (rd_lo),
        .hi       (hi),
        .lo       (lo),
        .busy     (busy),
        .done     (done),
        .stall    (stall)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference result {hi,lo} from plain integer arithmetic
    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = '0;
        case (op)
            2'b00: p = 64'(sa * sb);
            2'b01: p = {32'b0, a} * {32'b0, b};
            2'b10: begin
                if (b == 32'd0) p = {a, 32'hFFFFFFFF};
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    p = {32'(r), 32'(q)};
                end
            end
            default: begin
                if (b == 32'd0) p = {a, 32'hFFFFFFFF};
                else p = {a % b, a / b};
            end
        endcase
        return p;
    endfunction

    // Expected number of busy cycles for an operation
    function automatic int exp_busy(input logic [1:0] op, input logic [31:0] b);
        if (op[1]) return (b == 32'd0) ? 1 : 32;
`ifdef FAST_MUL_EN
        return 1;
`else
        return 32;
`endif
    endfunction

    task automatic wait_done(output int nb, output bit got);
        nb  = 0;
        got = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (done) begin
                got = 1'b1;
                break;
            end
            if (busy) nb++;
            @(negedge clk);
        end
    endtask

    task automatic do_op(input string name, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp);
        int nb;
        bit got;
        @(negedge clk);
        md_start = 1'b1;
        md_op    = op;
        src_a    = a;
        src_b    = b;
        @(negedge clk);
        md_start = 1'b0;
        wait_done(nb, got);
        check({name, " done_seen"}, 32'(got), 32'd1);
        check({name, " hi"}, hi, exp[63:32]);
        check({name, " lo"}, lo, exp[31:0]);
        check({name, " busy_low_at_done"}, 32'(busy), 32'd0);
        check({name, " busy_cycles"}, 32'(nb), 32'(exp_busy(op, b)));
        @(negedge clk);
        check({name, " done_one_cycle"}, 32'(done), 32'd0);
    endtask

    vec_t vecs[10];

    initial begin
        int nb;
        bit got;
        int cyc;
        int raise_at;
        int eb;
        int dcount;
        logic [1:0]  rop;
        logic [31:0] ra, rb;
        logic [63:0] e;
        logic [31:0] prev_lo;

        vecs[0] = '{2'b00, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1};
        vecs[1] = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[2] = '{2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        vecs[3] = '{2'b11, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF};
        vecs[4] = '{2'b10, 32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF};
        vecs[5] = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[6] = '{2'b11, 32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF};
        vecs[7] = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[8] = '{2'b00, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000001};
        vecs[9] = '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};

        rst = 1'b1; md_start = 1'b0; md_op = 2'b00; src_a = '0; src_b = '0;
        mthi = 1'b0; mtlo = 1'b0; wdata = '0; rd_hi = 1'b1; rd_lo = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("reset hi", hi, 32'h0);
        check("reset lo", lo, 32'h0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("idle rd_hi stall", 32'(stall), 32'd0);
        rd_hi = 1'b0;

        // Directed vector table
        for (int i = 0; i < 10; i++) begin
            do_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, {vecs[i].hi, vecs[i].lo});
        end

        // Randomized operations against the arithmetic model
        for (int i = 0; i < 30; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            case ($urandom_range(0, 9))
                0:       rb = 32'd0;
                1, 2:    rb = 32'($urandom_range(1, 20));
                3:       rb = 32'hFFFFFFFF;
                default: rb = $urandom;
            endcase
            do_op($sformatf("rand%0d", i), rop, ra, rb, model(rop, ra, rb));
        end

        // Stall while busy; second issue ignored until idle, then accepted
        @(negedge clk);
        md_start = 1'b1; md_op = 2'b00; src_a = 32'hFFFFFFFD; src_b = 32'h5;
        eb = exp_busy(2'b00, 32'h5);
        raise_at = (eb > 1) ? eb / 2 : 1;
        @(negedge clk);
        md_start = 1'b0;
        rd_lo = 1'b1;
        cyc = 0;
        for (int k = 0; k < 100; k++) begin
            if (!busy) break;
            check($sformatf("stall_busy c%0d", cyc), 32'(stall), 32'd1);
            cyc++;
            if (cyc == raise_at) begin
                md_start = 1'b1; md_op = 2'b01; src_a = 32'h00010000; src_b = 32'h00030000;
            end
            @(negedge clk);
        end
        check("stall seq busy_cycles", 32'(cyc), 32'(eb));
        check("stall seq done", 32'(done), 32'd1);
        check("stall seq stall_in_done", 32'(stall), 32'd0);
        check("stall seq first hi", hi, 32'hFFFFFFFF);
        check("stall seq first lo", lo, 32'hFFFFFFF1);
        @(negedge clk);
        md_start = 1'b0;
        rd_lo = 1'b0;
        check("stall seq second accepted", 32'(busy), 32'd1);
        wait_done(nb, got);
        e = model(2'b01, 32'h00010000, 32'h00030000);
        check("stall seq second done", 32'(got), 32'd1);
        check("stall seq second hi", hi, e[63:32]);
        check("stall seq second lo", lo, e[31:0]);

        // mthi/mtlo while idle
        @(negedge clk);
        prev_lo = lo;
        mthi = 1'b1; wdata = 32'hA5A5A5A5; rd_hi = 1'b1;
        #1;
        check("mthi no stall", 32'(stall), 32'd0);
        @(negedge clk);
        mthi = 1'b0; rd_hi = 1'b0;
        check("mthi hi", hi, 32'hA5A5A5A5);
        check("mthi lo kept", lo, prev_lo);
        mthi = 1'b1; mtlo = 1'b1; wdata = 32'h5A5A5A5A;
        @(negedge clk);
        mthi = 1'b0; mtlo = 1'b0;
        check("mthi+mtlo hi", hi, 32'h5A5A5A5A);
        check("mthi+mtlo lo", lo, 32'h5A5A5A5A);

        // md_start wins over a simultaneous mthi
        mthi = 1'b1; wdata = 32'h11111111;
        md_start = 1'b1; md_op = 2'b11; src_a = 32'd100; src_b = 32'd7;
        @(negedge clk);
        mthi = 1'b0; md_start = 1'b0;
        check("start_wins hi unchanged", hi, 32'h5A5A5A5A);
        check("start_wins busy", 32'(busy), 32'd1);
        wait_done(nb, got);
        check("start_wins hi", hi, 32'd2);
        check("start_wins lo", lo, 32'd14);

        // Reset in the middle of a divide
        @(negedge clk);
        md_start = 1'b1; md_op = 2'b10; src_a = 32'h00100000; src_b = 32'd3;
        @(negedge clk);
        md_start = 1'b0;
        repeat (9) @(negedge clk);
        check("pre_reset busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst busy", 32'(busy), 32'd0);
        check("midrst hi", hi, 32'h0);
        check("midrst lo", lo, 32'h0);
        dcount = 0;
        for (int k = 0; k < 40; k++) begin
            if (done) dcount++;
            @(negedge clk);
        end
        check("midrst no done", 32'(dcount), 32'd0);
        check("midrst hi held", hi, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
